mem_arbiter: RTL and testbench

- Shares the single Avalon-MM slave port of `mem_if` between two Avalon-MM masters:
  - m0: stimulus reader.
  - m1: result/log writer or any second client.
- Ownership is registered with a per-owner hold limit; the owner's request passes through combinationally.
- Outstanding reads are tagged in an owner FIFO so each returning `readdataready` reaches the master that issued the read.

---
 rtl/mem_arbiter.sv | 229 ++++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one Avalon-MM slave port (mem_if) between two masters.
// The current owner's request is passed straight through to mem_*; ownership
// is registered, with a per-grant hold limit so a busy master cannot starve
// the other. Outstanding reads are tagged with the issuing master's id in a
// small FIFO so each readdataready pulse goes back to the right master.
// Optional build macro: MEM_ARB_FIXED_PRIO_EN (m0 strict priority, no hold
// limit). Undefined gives round-robin with the MAX_HOLD limit.
module mem_arbiter #(
    parameter int ADDR_WIDTH  = 20,
    parameter int DATA_WIDTH  = 16,
    parameter int BE_WIDTH    = DATA_WIDTH / 8,
    parameter int MAX_PENDING = 8,
    parameter int PEND_WIDTH  = 3,
    parameter int MAX_HOLD    = 16,
    parameter int HOLD_WIDTH  = 5
) (
    input  logic                  clock,
    input  logic                  reset_n,
    // master 0
    input  logic [ADDR_WIDTH-1:0] m0_address,
    input  logic [BE_WIDTH-1:0]   m0_byteenable,
    input  logic                  m0_read,
    input  logic                  m0_write,
    input  logic [DATA_WIDTH-1:0] m0_writedata,
    output logic [DATA_WIDTH-1:0] m0_readdata,
    output logic                  m0_readdataready,
    output logic                  m0_waitrequest,
    // master 1
    input  logic [ADDR_WIDTH-1:0] m1_address,
    input  logic [BE_WIDTH-1:0]   m1_byteenable,
    input  logic                  m1_read,
    input  logic                  m1_write,
    input  logic [DATA_WIDTH-1:0] m1_writedata,
    output logic [DATA_WIDTH-1:0] m1_readdata,
    output logic                  m1_readdataready,
    output logic                  m1_waitrequest,
    // slave side towards mem_if
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [BE_WIDTH-1:0]   mem_byteenable,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [DATA_WIDTH-1:0] mem_writedata,
    input  logic [DATA_WIDTH-1:0] mem_readdata,
    input  logic                  mem_readdataready,
    input  logic                  mem_waitrequest,
    // sticky: a read response arrived with no read outstanding
    output logic                  err_orphan
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_OWN0 = 2'd1;
    localparam logic [1:0] ST_OWN1 = 2'd2;

    localparam logic [PEND_WIDTH:0]   PEND_MAX  = (PEND_WIDTH+1)'(MAX_PENDING);
    localparam logic [PEND_WIDTH:0]   PEND_ONE  = (PEND_WIDTH+1)'(1);
    localparam logic [PEND_WIDTH-1:0] PTR_ONE   = PEND_WIDTH'(1);
    localparam logic [HOLD_WIDTH-1:0] HOLD_MAX  = HOLD_WIDTH'(MAX_HOLD);
    localparam logic [HOLD_WIDTH-1:0] HOLD_LAST = HOLD_WIDTH'(MAX_HOLD - 1);
    localparam logic [HOLD_WIDTH-1:0] HOLD_ONE  = HOLD_WIDTH'(1);

    logic [1:0]            state_reg, state_next;
    logic                  last_reg, last_next;
    logic [HOLD_WIDTH-1:0] hold_reg, hold_next;
    logic [PEND_WIDTH:0]   count_reg;
    logic [PEND_WIDTH-1:0] wr_ptr_reg, rd_ptr_reg;
    logic                  err_orphan_reg;
    logic                  fifo_mem [MAX_PENDING];

    logic                  req_0, req_1;
    logic [ADDR_WIDTH-1:0] own_address;
    logic [BE_WIDTH-1:0]   own_byteenable;
    logic [DATA_WIDTH-1:0] own_writedata;
    logic                  own_read, own_write, own_id;
    logic                  pend_full, own_wait, accept, hold_at_limit;
    logic                  push, pop, orphan, head_id;

    assign req_0 = m0_read | m0_write;
    assign req_1 = m1_read | m1_write;

    // Mux the owner's request onto the slave side; IDLE drives all zeros.
    // A simultaneous read+write is treated as a read only.
    always_comb begin
        own_address    = '0;
        own_byteenable = '0;
        own_writedata  = '0;
        own_read       = 1'b0;
        own_write      = 1'b0;
        own_id         = 1'b0;
        case (state_reg)
            ST_OWN0: begin
                own_address    = m0_address;
                own_byteenable = m0_byteenable;
                own_writedata  = m0_writedata;
                own_read       = m0_read;
                own_write      = m0_write & ~m0_read;
            end
            ST_OWN1: begin
                own_address    = m1_address;
                own_byteenable = m1_byteenable;
                own_writedata  = m1_writedata;
                own_read       = m1_read;
                own_write      = m1_write & ~m1_read;
                own_id         = 1'b1;
            end
            default: ;
        endcase
    end

    // Full is judged on the registered count, so a pop in the same cycle
    // does not release the stall; the read is not presented to mem_if while
    // it cannot be tagged.
    assign pend_full     = (count_reg == PEND_MAX);
    assign own_wait      = mem_waitrequest | (own_read & pend_full);
    assign accept        = (state_reg != ST_IDLE) & (own_read | own_write) & ~own_wait;
    assign hold_at_limit = (hold_reg >= HOLD_LAST);

    assign push    = accept & own_read;
    assign pop     = mem_readdataready & (count_reg != '0);
    assign orphan  = mem_readdataready & (count_reg == '0);
    assign head_id = fifo_mem[rd_ptr_reg];

    assign mem_address    = own_address;
    assign mem_byteenable = own_byteenable;
    assign mem_writedata  = own_writedata;
    assign mem_read       = own_read & ~pend_full;
    assign mem_write      = own_write;

    assign m0_waitrequest   = (state_reg == ST_OWN0) ? own_wait : 1'b1;
    assign m1_waitrequest   = (state_reg == ST_OWN1) ? own_wait : 1'b1;
    assign m0_readdata      = mem_readdata;
    assign m1_readdata      = mem_readdata;
    assign m0_readdataready = pop & ~head_id;
    assign m1_readdataready = pop & head_id;
    assign err_orphan       = err_orphan_reg;

    // Ownership decision: who gets the port next cycle.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
`ifdef MEM_ARB_FIXED_PRIO_EN
                if (req_0)
                    state_next = ST_OWN0;
`else
                if (req_0 && (!req_1 || last_reg))
                    state_next = ST_OWN0;
`endif
                else if (req_1)
                    state_next = ST_OWN1;
            end
            ST_OWN0: begin
                if (!req_0)
                    state_next = req_1 ? ST_OWN1 : ST_IDLE;
`ifndef MEM_ARB_FIXED_PRIO_EN
                else if (accept && hold_at_limit && req_1)
                    state_next = ST_OWN1;
`endif
            end
            ST_OWN1: begin
                if (!req_1)
                    state_next = req_0 ? ST_OWN0 : ST_IDLE;
`ifdef MEM_ARB_FIXED_PRIO_EN
                else if (accept && req_0)
                    state_next = ST_OWN0;
`else
                else if (accept && hold_at_limit && req_0)
                    state_next = ST_OWN0;
`endif
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Hold counter restarts on every grant change and saturates at MAX_HOLD;
    // last remembers the most recent owner for round-robin tie-breaks.
    always_comb begin
        hold_next = hold_reg;
        last_next = last_reg;
        if (state_next != state_reg)
            hold_next = '0;
        else if (accept && (hold_reg != HOLD_MAX))
            hold_next = hold_reg + HOLD_ONE;
        if (state_next == ST_OWN0 && state_reg != ST_OWN0)
            last_next = 1'b0;
        else if (state_next == ST_OWN1 && state_reg != ST_OWN1)
            last_next = 1'b1;
    end

    // Ownership state registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= ST_IDLE;
            last_reg  <= 1'b1;
            hold_reg  <= '0;
        end else begin
            state_reg <= state_next;
            last_reg  <= last_next;
            hold_reg  <= hold_next;
        end
    end

    // Owner-tag FIFO pointers, occupancy and sticky orphan flag.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count_reg      <= '0;
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            err_orphan_reg <= 1'b0;
        end else begin
            if (push)
                wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            if (pop)
                rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
            if (push && !pop)
                count_reg <= count_reg + PEND_ONE;
            else if (pop && !push)
                count_reg <= count_reg - PEND_ONE;
            if (orphan)
                err_orphan_reg <= 1'b1;
        end
    end

    // Owner-tag storage; contents are meaningless while count is zero.
    always_ff @(posedge clock) begin
        if (push)
            fifo_mem[wr_ptr_reg] <= own_id;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter: a vector table for the
// single-master, orphan and ownership-handoff behaviour, then hand-written
// sequences for contention, interleaved reads, pending limit and reset.
module tb_mem_arbiter;

    localparam logic [1:0]  BE0 = 2'b01;
    localparam logic [1:0]  BE1 = 2'b10;
    localparam logic [15:0] WD0 = 16'h1111;
    localparam logic [15:0] WD1 = 16'h2222;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [19:0] m0_address, m1_address, mem_address;
    logic [1:0]  m0_byteenable, m1_byteenable, mem_byteenable;
    logic        m0_read, m0_write, m1_read, m1_write;
    logic [15:0] m0_writedata, m1_writedata, mem_writedata;
    logic [15:0] m0_readdata, m1_readdata, mem_readdata;
    logic        m0_readdataready, m1_readdataready, m0_waitrequest, m1_waitrequest;
    logic        mem_read, mem_write, mem_readdataready, mem_waitrequest, err_orphan;

    int checks = 0;
    int passed = 0;

    mem_arbiter dut (
        .clock(clock), .reset_n(reset_n),
        .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
        .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_readdata(m0_readdata),
        .m0_readdataready(m0_readdataready), .m0_waitrequest(m0_waitrequest),
        .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
        .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_readdata(m1_readdata),
        .m1_readdataready(m1_readdataready), .m1_waitrequest(m1_waitrequest),
        .mem_address(mem_address), .mem_byteenable(mem_byteenable), .mem_read(mem_read),
        .mem_write(mem_write), .mem_writedata(mem_writedata), .mem_readdata(mem_readdata),
        .mem_readdataready(mem_readdataready), .mem_waitrequest(mem_waitrequest),
        .err_orphan(err_orphan)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        r0, w0;
        logic [19:0] a0;
        logic        r1, w1;
        logic [19:0] a1;
        logic        mwait, mrdy;
        logic [15:0] mrdata;
        logic        ew0, ew1, emr, emw;
        logic [19:0] emaddr;
        logic [1:0]  ebe;
        logic [15:0] ewd;
        logic        erdy0, erdy1, eerr;
    } vec_t;

    localparam int NV = 15;
    vec_t vec [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp)
            passed++;
        else
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic clear_inputs();
        m0_address = '0; m0_byteenable = BE0; m0_read = 1'b0; m0_write = 1'b0; m0_writedata = WD0;
        m1_address = '0; m1_byteenable = BE1; m1_read = 1'b0; m1_write = 1'b0; m1_writedata = WD1;
        mem_readdata = '0; mem_readdataready = 1'b0; mem_waitrequest = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset_n = 1'b0;
        clear_inputs();
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        #1;
        check("rst.wait", {31'd0, m0_waitrequest & m1_waitrequest}, 32'd1);
        check("rst.mem_rw", {30'd0, mem_read, mem_write}, 32'd0);
        check("rst.err", {31'd0, err_orphan}, 32'd0);
    endtask

    initial begin
        clear_inputs();
        // r0 w0 a0 | r1 w1 a1 | mwait mrdy mrdata | ew0 ew1 emr emw emaddr ebe ewd erdy0 erdy1 eerr
        vec[0]  = '{1'b1,1'b0,20'h0,  1'b0,1'b0,20'h0,  1'b0,1'b0,16'h0,    1'b1,1'b1,1'b0,1'b0,20'h0,  2'b00,16'h0,1'b0,1'b0,1'b0};
        vec[1]  = '{1'b1,1'b0,20'h0,  1'b0,1'b0,20'h0,  1'b0,1'b0,16'h0,    1'b0,1'b1,1'b1,1'b0,20'h0,  BE0,WD0,1'b0,1'b0,1'b0};
        vec[2]  = '{1'b1,1'b0,20'h1,  1'b0,1'b0,20'h0,  1'b0,1'b0,16'h0,    1'b0,1'b1,1'b1,1'b0,20'h1,  BE0,WD0,1'b0,1'b0,1'b0};
        vec[3]  = '{1'b1,1'b0,20'h2,  1'b0,1'b0,20'h0,  1'b0,1'b1,16'hA000, 1'b0,1'b1,1'b1,1'b0,20'h2,  BE0,WD0,1'b1,1'b0,1'b0};
        vec[4]  = '{1'b1,1'b0,20'h3,  1'b0,1'b0,20'h0,  1'b0,1'b1,16'hA001, 1'b0,1'b1,1'b1,1'b0,20'h3,  BE0,WD0,1'b1,1'b0,1'b0};
        vec[5]  = '{1'b0,1'b0,20'h3,  1'b0,1'b0,20'h0,  1'b0,1'b1,16'hA002, 1'b0,1'b1,1'b0,1'b0,20'h3,  BE0,WD0,1'b1,1'b0,1'b0};
        vec[6]  = '{1'b0,1'b0,20'h0,  1'b0,1'b0,20'h0,  1'b0,1'b1,16'hA003, 1'b1,1'b1,1'b0,1'b0,20'h0,  2'b00,16'h0,1'b1,1'b0,1'b0};
        vec[7]  = '{1'b0,1'b0,20'h0,  1'b0,1'b0,20'h0,  1'b0,1'b1,16'hBEEF, 1'b1,1'b1,1'b0,1'b0,20'h0,  2'b00,16'h0,1'b0,1'b0,1'b0};
        vec[8]  = '{1'b0,1'b0,20'h0,  1'b0,1'b1,20'h55, 1'b0,1'b0,16'h0,    1'b1,1'b1,1'b0,1'b0,20'h0,  2'b00,16'h0,1'b0,1'b0,1'b1};
        vec[9]  = '{1'b0,1'b0,20'h0,  1'b0,1'b1,20'h55, 1'b0,1'b0,16'h0,    1'b1,1'b0,1'b0,1'b1,20'h55, BE1,WD1,1'b0,1'b0,1'b1};
        vec[10] = '{1'b0,1'b0,20'h0,  1'b0,1'b1,20'h56, 1'b1,1'b0,16'h0,    1'b1,1'b1,1'b0,1'b1,20'h56, BE1,WD1,1'b0,1'b0,1'b1};
        vec[11] = '{1'b1,1'b0,20'h7,  1'b0,1'b1,20'h56, 1'b0,1'b0,16'h0,    1'b1,1'b0,1'b0,1'b1,20'h56, BE1,WD1,1'b0,1'b0,1'b1};
        vec[12] = '{1'b1,1'b0,20'h7,  1'b0,1'b0,20'h57, 1'b0,1'b0,16'h0,    1'b1,1'b0,1'b0,1'b0,20'h57, BE1,WD1,1'b0,1'b0,1'b1};
        vec[13] = '{1'b1,1'b1,20'h7,  1'b0,1'b0,20'h0,  1'b0,1'b0,16'h0,    1'b0,1'b1,1'b1,1'b0,20'h7,  BE0,WD0,1'b0,1'b0,1'b1};
        vec[14] = '{1'b0,1'b0,20'h7,  1'b0,1'b0,20'h0,  1'b0,1'b1,16'hC0DE, 1'b0,1'b1,1'b0,1'b0,20'h7,  BE0,WD0,1'b1,1'b0,1'b1};

        // Reset state straight out of power-up reset.
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        #1;
        check("init.m0_wait", {31'd0, m0_waitrequest}, 32'd1);
        check("init.m1_wait", {31'd0, m1_waitrequest}, 32'd1);
        check("init.mem_addr", {12'd0, mem_address}, 32'd0);
        check("init.err", {31'd0, err_orphan}, 32'd0);

        for (int i = 0; i < NV; i++) begin
            @(negedge clock);
            m0_read = vec[i].r0; m0_write = vec[i].w0; m0_address = vec[i].a0;
            m1_read = vec[i].r1; m1_write = vec[i].w1; m1_address = vec[i].a1;
            mem_waitrequest = vec[i].mwait; mem_readdataready = vec[i].mrdy;
            mem_readdata = vec[i].mrdata;
            #1;
            check($sformatf("v%0d.m0_wait", i), {31'd0, m0_waitrequest}, {31'd0, vec[i].ew0});
            check($sformatf("v%0d.m1_wait", i), {31'd0, m1_waitrequest}, {31'd0, vec[i].ew1});
            check($sformatf("v%0d.mem_read", i), {31'd0, mem_read}, {31'd0, vec[i].emr});
            check($sformatf("v%0d.mem_write", i), {31'd0, mem_write}, {31'd0, vec[i].emw});
            check($sformatf("v%0d.mem_addr", i), {12'd0, mem_address}, {12'd0, vec[i].emaddr});
            check($sformatf("v%0d.mem_be", i), {30'd0, mem_byteenable}, {30'd0, vec[i].ebe});
            check($sformatf("v%0d.mem_wd", i), {16'd0, mem_writedata}, {16'd0, vec[i].ewd});
            check($sformatf("v%0d.m0_rdy", i), {31'd0, m0_readdataready}, {31'd0, vec[i].erdy0});
            check($sformatf("v%0d.m1_rdy", i), {31'd0, m1_readdataready}, {31'd0, vec[i].erdy1});
            check($sformatf("v%0d.err", i), {31'd0, err_orphan}, {31'd0, vec[i].eerr});
            check($sformatf("v%0d.rdata", i), {m0_readdata, m1_readdata}, {vec[i].mrdata, vec[i].mrdata});
        end

`ifndef MEM_ARB_FIXED_PRIO_EN
        // Contention: both write continuously; runs of 16 accepts, m0 first.
        do_reset();
        for (int k = 0; k < 65; k++) begin
            @(negedge clock);
            m0_write = 1'b1; m1_write = 1'b1;
            #1;
            if (k == 0)
                check($sformatf("cont%0d.wait", k), {30'd0, m0_waitrequest, m1_waitrequest}, 32'd3);
            else if ((((k - 1) / 16) % 2) == 0)
                check($sformatf("cont%0d.wait", k), {30'd0, m0_waitrequest, m1_waitrequest}, 32'd1);
            else
                check($sformatf("cont%0d.wait", k), {30'd0, m0_waitrequest, m1_waitrequest}, 32'd2);
        end
`else
        // Fixed priority: m1 owns, m0 requests -> OWN0 after m1's next accept.
        do_reset();
        @(negedge clock); m1_write = 1'b1; #1;
        check("fp.idle", {31'd0, m1_waitrequest}, 32'd1);
        @(negedge clock); #1;
        check("fp.m1_own", {30'd0, m0_waitrequest, m1_waitrequest}, 32'd2);
        @(negedge clock); m0_read = 1'b1; #1;
        check("fp.m1_accept", {30'd0, m0_waitrequest, m1_waitrequest}, 32'd2);
        @(negedge clock); #1;
        check("fp.m0_own", {30'd0, m0_waitrequest, m1_waitrequest}, 32'd1);
`endif

        // Interleaved reads: m0 x3, handoff, m1 x2, late responses.
        do_reset();
        @(negedge clock); m0_read = 1'b1; m0_address = 20'd10; #1;
        check("il.idle", {31'd0, m0_waitrequest}, 32'd1);
        for (int j = 0; j < 3; j++) begin
            @(negedge clock); m0_address = 20'd10 + 20'(j); #1;
            check($sformatf("il.m0rd%0d", j), {30'd0, m0_waitrequest, mem_read}, 32'd1);
        end
        @(negedge clock); m0_read = 1'b0; m1_read = 1'b1; m1_address = 20'd20; #1;
        check("il.handoff", {31'd0, m1_waitrequest}, 32'd1);
        for (int j = 0; j < 2; j++) begin
            @(negedge clock); m1_address = 20'd20 + 20'(j); #1;
            check($sformatf("il.m1rd%0d", j), {11'd0, m1_waitrequest, mem_address}, {12'd0, 20'd20 + 20'(j)});
        end
        @(negedge clock); m1_read = 1'b0;
        for (int j = 0; j < 5; j++) begin
            @(negedge clock); mem_readdataready = 1'b1; mem_readdata = 16'(j); #1;
            check($sformatf("il.resp%0d", j), {30'd0, m0_readdataready, m1_readdataready},
                  (j < 3) ? 32'd2 : 32'd1);
        end
        @(negedge clock); mem_readdataready = 1'b0; #1;
        check("il.err", {31'd0, err_orphan}, 32'd0);

        // Pending limit: 8 outstanding stalls the 9th until a pop registers.
        do_reset();
        @(negedge clock); m0_read = 1'b1;
        for (int j = 0; j < 8; j++) begin
            @(negedge clock); m0_address = 20'(j); #1;
            check($sformatf("pl.rd%0d", j), {31'd0, m0_waitrequest}, 32'd0);
        end
        for (int j = 0; j < 2; j++) begin
            @(negedge clock); m0_address = 20'd8; #1;
            check($sformatf("pl.full%0d", j), {30'd0, m0_waitrequest, mem_read}, 32'd2);
        end
        @(negedge clock); mem_readdataready = 1'b1; #1;
        check("pl.pop_same", {30'd0, m0_waitrequest, m0_readdataready}, 32'd3);
        @(negedge clock); mem_readdataready = 1'b0; #1;
        check("pl.accept", {30'd0, m0_waitrequest, mem_read}, 32'd1);
        @(negedge clock); m0_read = 1'b0;
        for (int j = 0; j < 8; j++) begin
            @(negedge clock); mem_readdataready = 1'b1; #1;
            check($sformatf("pl.drain%0d", j), {30'd0, m0_readdataready, m1_readdataready}, 32'd2);
        end
        @(negedge clock); mem_readdataready = 1'b0; #1;
        check("pl.err", {31'd0, err_orphan}, 32'd0);

        // Reset mid-burst: outstanding reads become orphans.
        do_reset();
        @(negedge clock); m0_read = 1'b1;
        @(negedge clock); m0_address = 20'd1;
        @(negedge clock); m0_address = 20'd2;
        @(negedge clock); reset_n = 1'b0; #1;
        check("mr.wait", {30'd0, m0_waitrequest, m1_waitrequest}, 32'd3);
        check("mr.mem", {10'd0, mem_read, mem_write, mem_address}, 32'd0);
        clear_inputs();
        @(negedge clock); reset_n = 1'b1;
        @(negedge clock); mem_readdataready = 1'b1; #1;
        check("mr.orphan_rdy", {30'd0, m0_readdataready, m1_readdataready}, 32'd0);
        @(negedge clock); mem_readdataready = 1'b0; #1;
        check("mr.err", {31'd0, err_orphan}, 32'd1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
